// File: rtl/nios_dbg_pkg.sv
// Shared types and default geometry for the Nios II debug command dispatcher.
// Purely declarative: no logic, no latency, no backpressure.
package nios_dbg_pkg;

  localparam int DEF_DATA_W      = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_FIFO_DEPTH  = 4;

  localparam int NUM_CH     = 1 << DEF_IR_W;
  localparam int LVL_W      = $clog2(DEF_FIFO_DEPTH) + 1;
  localparam int ACTION_BIT = DEF_DATA_W - 1;

  typedef struct packed {
    logic [DEF_IR_W-1:0]   ir;
    logic [DEF_DATA_W-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/nios_dbg_cmd_dispatch_if.sv
// Command hand-off from the dispatcher to the OCI core: head command plus take_* pulses.
// Valid/ready: the command is consumed in any cycle where cmd_valid and cmd_ready are both high.
interface nios_dbg_cmd_dispatch_if
  import nios_dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IR_W   = DEF_IR_W
);
  localparam int N_CH = 1 << IR_W;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   cmd_ir;
  logic [N_CH-1:0]   take_action;
  logic [N_CH-1:0]   take_no_action;

  modport master (
    output cmd_valid, jdo, cmd_ir, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, jdo, cmd_ir, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/nios_dbg_sync_edge.sv
// Synchronises an async level into clk and emits a registered one-cycle pulse on its rise.
// Latency STAGES+1 clk from input rise to pulse; no backpressure, pulses masked while blank is high.
module nios_dbg_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic blank,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              last;

  // last keeps tracking during blanking so a level held high through reset never looks like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      last <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      last <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~last & ~blank;
    end
  end

endmodule

// File: rtl/nios_dbg_cmd_dispatch.sv
// Captures {ir, sr} on synced update-DR edges into a small queue and issues one-hot take_* pulses on accept.
// cmd_valid SYNC_STAGES+2 clk after vs_udr rise; pushes into a full queue without a pop are dropped (sticky overflow). Optional NIOS_DBG_CMD_PARITY_EN.
module nios_dbg_cmd_dispatch
  import nios_dbg_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DATA_W-1:0]             sr,
  nios_dbg_cmd_dispatch_if.master       cmd_if,
  output logic                          uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef NIOS_DBG_CMD_PARITY_EN
  ,
  input  logic                          sr_par,
  output logic                          parity_err,
  output logic [7:0]                    err_cnt
`endif
);

  localparam int N_CH    = 1 << IR_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LV_W    = AW + 1;
  localparam int ACT_BIT = DATA_W - 1;
  localparam int BLK_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [N_CH-1:0] CH_ONE = N_CH'(1);

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic [BLK_W-1:0] blank_cnt;
  logic             blank;
  logic             udr_rise;
  logic             push, pop, wr_en, empty, full;
  logic [LV_W-1:0]  wr_cnt, rd_cnt, level;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;

  always_ff @(posedge clk) begin
    if (reset)
      blank_cnt <= BLK_W'(SYNC_STAGES + 1);
    else if (blank_cnt != '0)
      blank_cnt <= blank_cnt - BLK_W'(1);
  end
  assign blank = (blank_cnt != '0);

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .async_in(vs_udr), .blank(blank), .rise(udr_rise)
  );

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .async_in(vs_uir), .blank(blank), .rise(uir_pulse)
  );

`ifdef NIOS_DBG_CMD_PARITY_EN
  logic par_ok;
  assign par_ok = ^{ir_in, sr, sr_par};
  assign push   = udr_rise & par_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
      err_cnt    <= '0;
    end else begin
      parity_err <= udr_rise & ~par_ok;
      if (udr_rise && !par_ok && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign push = udr_rise;
`endif

  assign level = wr_cnt - rd_cnt;
  assign empty = (level == '0);
  assign full  = (level == LV_W'(FIFO_DEPTH));
  assign pop   = cmd_if.cmd_valid & cmd_if.cmd_ready;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_cnt[AW-1:0]] <= '{ir: ir_in, data: sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_cnt <= wr_cnt + LV_W'(1);
      if (pop)
        rd_cnt <= rd_cnt + LV_W'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign head             = mem[rd_cnt[AW-1:0]];
  assign fifo_level       = level;
  assign cmd_if.cmd_valid = ~empty;
  assign cmd_if.jdo       = empty ? '0 : head.data;
  assign cmd_if.cmd_ir    = empty ? '0 : head.ir;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_if.take_action    <= '0;
      cmd_if.take_no_action <= '0;
    end else begin
      cmd_if.take_action    <= '0;
      cmd_if.take_no_action <= '0;
      if (pop) begin
        if (head.data[ACT_BIT])
          cmd_if.take_action <= CH_ONE << head.ir;
        else
          cmd_if.take_no_action <= CH_ONE << head.ir;
      end
    end
  end

endmodule

// File: tb/tb_nios_dbg_cmd_dispatch.sv
// Directed bench for nios_dbg_cmd_dispatch: latency, dispatch polarity, overflow, full push+pop, reset blanking.
// Optional parity checks build only with NIOS_DBG_CMD_PARITY_EN.
module tb_nios_dbg_cmd_dispatch;
  import nios_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        uir_pulse;
  logic [2:0]  fifo_level;
  logic        overflow;
`ifdef NIOS_DBG_CMD_PARITY_EN
  logic        sr_par;
  logic        parity_err;
  logic [7:0]  err_cnt;
  bit          bad_par = 1'b0;
`endif

  always #5 clk = ~clk;

  nios_dbg_cmd_dispatch_if #(.DATA_W(38), .IR_W(2)) cmd_if ();

  nios_dbg_cmd_dispatch dut (
    .clk        (clk),
    .reset      (reset),
    .vs_udr     (vs_udr),
    .vs_uir     (vs_uir),
    .ir_in      (ir_in),
    .sr         (sr),
    .cmd_if     (cmd_if.master),
    .uir_pulse  (uir_pulse),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef NIOS_DBG_CMD_PARITY_EN
    ,
    .sr_par     (sr_par),
    .parity_err (parity_err),
    .err_cnt    (err_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  dbg_cmd_t vec [5] = '{
    '{ir: 2'd0, data: 38'h20_0000_0010},
    '{ir: 2'd1, data: 38'h00_0000_0011},
    '{ir: 2'd2, data: 38'h20_0000_0012},
    '{ir: 2'd3, data: 38'h00_0000_0013},
    '{ir: 2'd0, data: 38'h20_0000_0014}
  };
  dbg_cmd_t extra = '{ir: 2'd3, data: 38'h20_0000_0055};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir;
    sr    = d;
`ifdef NIOS_DBG_CMD_PARITY_EN
    sr_par = ~(^{ir, d}) ^ bad_par;
`endif
  endtask

  task automatic drive_udr(input dbg_cmd_t c);
    @(negedge clk);
    set_cmd(c.ir, c.data);
    vs_udr = 1'b1;
    repeat (6) @(negedge clk);
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic drain_one(input string tag, input dbg_cmd_t e);
    logic [3:0] oh;
    oh = 4'b0001 << e.ir;
    check({tag, "_ir"},  64'(cmd_if.cmd_ir), 64'(e.ir));
    check({tag, "_jdo"}, 64'(cmd_if.jdo),    64'(e.data));
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    check({tag, "_act"},   64'(cmd_if.take_action),    64'(e.data[37] ? oh : 4'b0000));
    check({tag, "_noact"}, 64'(cmd_if.take_no_action), 64'(e.data[37] ? 4'b0000 : oh));
  endtask

  initial begin
    logic any_valid;
    reset  = 1'b1;
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    set_cmd(2'd0, 38'h0);
    cmd_if.cmd_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(cmd_if.cmd_valid), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_ovf",   64'(overflow), 64'(0));
    check("rst_take",  64'({cmd_if.take_action, cmd_if.take_no_action}), 64'(0));
    check("rst_uir",   64'(uir_pulse), 64'(0));
    check("rst_jdo",   64'(cmd_if.jdo), 64'(0));
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // 1: action command, latency SYNC_STAGES+2
    cmd_if.cmd_ready = 1'b1;
    set_cmd(2'b01, 38'h20_0000_0ABC);
    vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_valid_early", 64'(cmd_if.cmd_valid), 64'(0));
    @(negedge clk);
    check("t1_valid", 64'(cmd_if.cmd_valid), 64'(1));
    check("t1_jdo",   64'(cmd_if.jdo), 64'(38'h20_0000_0ABC));
    check("t1_ir",    64'(cmd_if.cmd_ir), 64'(1));
    check("t1_level", 64'(fifo_level), 64'(1));
    @(negedge clk);
    check("t1_act",   64'(cmd_if.take_action), 64'(4'b0010));
    check("t1_noact", 64'(cmd_if.take_no_action), 64'(0));
    check("t1_popped", 64'(fifo_level), 64'(0));
    @(negedge clk);
    check("t1_act_pulse", 64'(cmd_if.take_action), 64'(0));
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);

    // 2: no-action command
    set_cmd(2'b01, 38'h00_0000_0ABC);
    vs_udr = 1'b1;
    repeat (5) @(negedge clk);
    check("t2_valid", 64'(cmd_if.cmd_valid), 64'(1));
    @(negedge clk);
    check("t2_noact", 64'(cmd_if.take_no_action), 64'(4'b0010));
    check("t2_act",   64'(cmd_if.take_action), 64'(0));
    @(negedge clk);
    check("t2_noact_pulse", 64'(cmd_if.take_no_action), 64'(0));
    vs_udr = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    repeat (5) @(negedge clk);

    // 3: overflow on fifth push, uir unaffected by full queue, drain order
    for (int k = 0; k < 5; k++) drive_udr(vec[k]);
    check("t3_level", 64'(fifo_level), 64'(4));
    check("t3_ovf",   64'(overflow), 64'(1));
    vs_uir = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_uir_early", 64'(uir_pulse), 64'(0));
    @(negedge clk);
    check("t3_uir", 64'(uir_pulse), 64'(1));
    @(negedge clk);
    check("t3_uir_pulse", 64'(uir_pulse), 64'(0));
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) drain_one($sformatf("t3_d%0d", k), vec[k]);
    check("t3_empty",    64'(cmd_if.cmd_valid), 64'(0));
    check("t3_ovf_hold", 64'(overflow), 64'(1));

    // 5: full queue, push and pop in the same cycle
    do_reset();
    check("t5_ovf_clr", 64'(overflow), 64'(0));
    for (int k = 0; k < 4; k++) drive_udr(vec[k]);
    check("t5_full", 64'(fifo_level), 64'(4));
    @(negedge clk);
    set_cmd(extra.ir, extra.data);
    vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    check("t5_level", 64'(fifo_level), 64'(4));
    check("t5_ovf",   64'(overflow), 64'(0));
    check("t5_act",   64'(cmd_if.take_action), 64'(4'b0001));
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 1; k < 4; k++) drain_one($sformatf("t5_d%0d", k), vec[k]);
    drain_one("t5_new", extra);
    check("t5_drained", 64'(fifo_level), 64'(0));

    // 4: reset mid-operation with vs_udr held high through release
    drive_udr(vec[1]);
    check("t4_level_pre", 64'(fifo_level), 64'(1));
    cmd_if.cmd_ready = 1'b1;
    reset  = 1'b1;
    vs_udr = 1'b1;
    @(negedge clk);
    check("t4_take_supp", 64'({cmd_if.take_action, cmd_if.take_no_action}), 64'(0));
    cmd_if.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_valid = any_valid | cmd_if.cmd_valid;
    end
    check("t4_no_push", 64'(any_valid), 64'(0));
    check("t4_level",   64'(fifo_level), 64'(0));
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);

`ifdef NIOS_DBG_CMD_PARITY_EN
    // 6: parity error drops the command and counts, saturating at 255
    bad_par = 1'b1;
    set_cmd(2'b01, 38'h20_0000_0ABC);
    vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_perr_early", 64'(parity_err), 64'(0));
    @(negedge clk);
    check("t6_perr",  64'(parity_err), 64'(1));
    check("t6_cnt1",  64'(err_cnt), 64'(1));
    check("t6_level", 64'(fifo_level), 64'(0));
    @(negedge clk);
    check("t6_perr_pulse", 64'(parity_err), 64'(0));
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 1; i < 300; i++) drive_udr(vec[0]);
    check("t6_sat",   64'(err_cnt), 64'(255));
    check("t6_level_end", 64'(fifo_level), 64'(0));
    bad_par = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
